// File: rtl/booth_dot_accumulator.sv
// Saturating signed dot-product accumulator fed by a stream of Booth products.
// Closes a vector on prod_last or at MAX_LEN beats and holds the result until it is accepted.
module booth_dot_accumulator #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int MAX_LEN    = 256,
    localparam int CW        = $clog2(MAX_LEN + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      prod_valid,
    output logic                      prod_ready,
    input  logic [2*DATA_WIDTH-1:0]   prod_data,
    input  logic                      prod_last,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [ACC_WIDTH-1:0]      res_data,
    output logic [CW-1:0]             res_count,
    output logic                      res_sat,
    output logic                      err_len
);

    localparam int PW = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                 state_q;
    logic [ACC_WIDTH-1:0]   acc_q;
    logic [CW-1:0]          cnt_q;
    logic                   sat_q;
    logic                   prod_ready_q;
    logic                   res_valid_q;
    logic [ACC_WIDTH-1:0]   res_data_q;
    logic [CW-1:0]          res_count_q;
    logic                   res_sat_q;
    logic                   err_len_q;

    logic [ACC_WIDTH:0]     sum_wide;
    logic [ACC_WIDTH-1:0]   acc_d;
    logic [CW-1:0]          cnt_d;
    logic                   clamp;
    logic                   accept;
    logic                   close;

    // One guard bit catches overflow: the top two bits of the wide sum disagree.
    always_comb begin
        sum_wide = {acc_q[ACC_WIDTH-1], acc_q}
                 + {{(ACC_WIDTH + 1 - PW){prod_data[PW-1]}}, prod_data};
        clamp    = sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1];
        acc_d    = sum_wide[ACC_WIDTH-1:0];
        if (clamp) begin
            acc_d = sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                        : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
        cnt_d  = cnt_q + CW'(1);
        accept = prod_valid && prod_ready_q;
        close  = prod_last || (cnt_d == CW'(MAX_LEN));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            sat_q        <= 1'b0;
            prod_ready_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_count_q  <= '0;
            res_sat_q    <= 1'b0;
            err_len_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_ACCUM: begin
                    prod_ready_q <= 1'b1;
                    if (accept) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        sat_q <= sat_q | clamp;
                        if (close) begin
                            res_data_q   <= acc_d;
                            res_count_q  <= cnt_d;
                            res_sat_q    <= sat_q | clamp;
                            err_len_q    <= !prod_last;
                            res_valid_q  <= 1'b1;
                            prod_ready_q <= 1'b0;
                            state_q      <= S_HOLD;
                        end else begin
                            state_q <= S_ACCUM;
                        end
                    end
                end
                S_HOLD: begin
                    if (res_ready) begin
                        res_valid_q  <= 1'b0;
                        acc_q        <= '0;
                        cnt_q        <= '0;
                        sat_q        <= 1'b0;
                        prod_ready_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    prod_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign prod_ready = prod_ready_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_count  = res_count_q;
    assign res_sat    = res_sat_q;
    assign err_len    = err_len_q;

endmodule

// File: tb/tb_booth_dot_accumulator.sv
// Directed bench for booth_dot_accumulator: three instances cover the default
// configuration, an 18-bit accumulator for saturation, and MAX_LEN=4 for force-close.
module tb_booth_dot_accumulator;

    logic clk;
    logic rst;
    logic              pv[3];
    logic              pl[3];
    logic              rr[3];
    logic [15:0]       pd[3];
    logic              pr[3];
    logic              rv[3];
    logic              rs[3];
    logic              el[3];
    logic signed [23:0] rd[3];
    logic [8:0]        rc[3];

    logic [17:0] rd_b;
    logic [2:0]  rc_c;

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    booth_dot_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(24), .MAX_LEN(256)) dut_a (
        .clk(clk), .rst(rst),
        .prod_valid(pv[0]), .prod_ready(pr[0]), .prod_data(pd[0]), .prod_last(pl[0]),
        .res_valid(rv[0]), .res_ready(rr[0]), .res_data(rd[0]), .res_count(rc[0]),
        .res_sat(rs[0]), .err_len(el[0])
    );

    booth_dot_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(18), .MAX_LEN(256)) dut_b (
        .clk(clk), .rst(rst),
        .prod_valid(pv[1]), .prod_ready(pr[1]), .prod_data(pd[1]), .prod_last(pl[1]),
        .res_valid(rv[1]), .res_ready(rr[1]), .res_data(rd_b), .res_count(rc[1]),
        .res_sat(rs[1]), .err_len(el[1])
    );

    booth_dot_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(24), .MAX_LEN(4)) dut_c (
        .clk(clk), .rst(rst),
        .prod_valid(pv[2]), .prod_ready(pr[2]), .prod_data(pd[2]), .prod_last(pl[2]),
        .res_valid(rv[2]), .res_ready(rr[2]), .res_data(rd[2]), .res_count(rc_c),
        .res_sat(rs[2]), .err_len(el[2])
    );

    assign rd[1] = {{6{rd_b[17]}}, rd_b};
    assign rc[2] = {6'd0, rc_c};

    // Drives one beat and returns #1 after the edge on which it was accepted.
    task automatic beat(input int d, input logic [15:0] data, input logic last);
        int n;
        n = 0;
        pv[d] = 1'b1;
        pd[d] = data;
        pl[d] = last;
        while (pr[d] !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++; failures++;
            $display("FAIL beat_timeout dut=%0d prod_ready=%b required 1", d, pr[d]);
        end
        @(posedge clk); #1;
        pv[d] = 1'b0;
    endtask

    task automatic take_result(input int d);
        rr[d] = 1'b1;
        @(posedge clk); #1;
        rr[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            pv[d] = 1'b0; pl[d] = 1'b0; rr[d] = 1'b0; pd[d] = 16'h0000;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (pr[d] !== 1'b0 || rv[d] !== 1'b0 || rd[d] !== 24'sd0 || rc[d] !== 9'd0
                || rs[d] !== 1'b0 || el[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_values dut=%0d got ready=%b valid=%b data=%0d count=%0d sat=%b err=%b required all 0",
                         d, pr[d], rv[d], rd[d], rc[d], rs[d], el[d]);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (pr[d] !== 1'b1) begin
                failures++;
                $display("FAIL ready_after_reset dut=%0d got %b required 1", d, pr[d]);
            end
        end
    endtask

    task automatic test_single();
        beat(0, 16'h0006, 1'b1);
        checks++;
        if (rv[0] !== 1'b1 || rd[0] !== 24'sd6 || rc[0] !== 9'd1 || rs[0] !== 1'b0 || el[0] !== 1'b0) begin
            failures++;
            $display("FAIL single_beat got valid=%b data=%0d count=%0d sat=%b err=%b required 1 6 1 0 0",
                     rv[0], rd[0], rc[0], rs[0], el[0]);
        end
        take_result(0);
        checks++;
        if (rv[0] !== 1'b0 || pr[0] !== 1'b1) begin
            failures++;
            $display("FAIL single_handshake got valid=%b ready=%b required 0 1", rv[0], pr[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals[3];
        vals[0] = 16'hFFFA;
        vals[1] = 16'h0014;
        vals[2] = 16'hFFFD;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pr[0] !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready beat=%0d got %b required 1", i, pr[0]);
            end
            beat(0, vals[i], i == 2);
        end
        checks++;
        if (rv[0] !== 1'b1 || rd[0] !== 24'sd11 || rc[0] !== 9'd3 || rs[0] !== 1'b0 || el[0] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_result got valid=%b data=%0d count=%0d sat=%b err=%b required 1 11 3 0 0",
                     rv[0], rd[0], rc[0], rs[0], el[0]);
        end
        take_result(0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 9; i++) beat(1, 16'h4000, i == 8);
        checks++;
        if (rv[1] !== 1'b1 || rd[1] !== 24'sd131071 || rc[1] !== 9'd9 || rs[1] !== 1'b1 || el[1] !== 1'b0) begin
            failures++;
            $display("FAIL sat_pos got valid=%b data=%0d count=%0d sat=%b err=%b required 1 131071 9 1 0",
                     rv[1], rd[1], rc[1], rs[1], el[1]);
        end
        take_result(1);
        for (int i = 0; i < 9; i++) beat(1, 16'hC080, i == 8);
        checks++;
        if (rv[1] !== 1'b1 || rd[1] !== -24'sd131072 || rc[1] !== 9'd9 || rs[1] !== 1'b1 || el[1] !== 1'b0) begin
            failures++;
            $display("FAIL sat_neg got valid=%b data=%0d count=%0d sat=%b err=%b required 1 -131072 9 1 0",
                     rv[1], rd[1], rc[1], rs[1], el[1]);
        end
        take_result(1);
        // Sticky sat must clear for the following unsaturated vector.
        beat(1, 16'h0003, 1'b1);
        checks++;
        if (rd[1] !== 24'sd3 || rs[1] !== 1'b0) begin
            failures++;
            $display("FAIL sat_cleared got data=%0d sat=%b required 3 0", rd[1], rs[1]);
        end
        take_result(1);
    endtask

    task automatic test_backpressure();
        beat(0, 16'h0002, 1'b1);
        pv[0] = 1'b1; pd[0] = 16'h0009; pl[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (pr[0] !== 1'b0 || rv[0] !== 1'b1 || rd[0] !== 24'sd2 || rc[0] !== 9'd1) begin
                failures++;
                $display("FAIL backpressure cycle=%0d got ready=%b valid=%b data=%0d count=%0d required 0 1 2 1",
                         i, pr[0], rv[0], rd[0], rc[0]);
            end
        end
        rr[0] = 1'b1;
        @(posedge clk); #1;
        rr[0] = 1'b0;
        checks++;
        if (rv[0] !== 1'b0 || pr[0] !== 1'b1) begin
            failures++;
            $display("FAIL bp_handshake got valid=%b ready=%b required 0 1", rv[0], pr[0]);
        end
        @(posedge clk); #1;
        pv[0] = 1'b0;
        checks++;
        if (rv[0] !== 1'b1 || rd[0] !== 24'sd9 || rc[0] !== 9'd1) begin
            failures++;
            $display("FAIL bp_next_vector got valid=%b data=%0d count=%0d required 1 9 1", rv[0], rd[0], rc[0]);
        end
        take_result(0);
    endtask

    task automatic test_max_len();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rv[2] !== 1'b0) begin
                failures++;
                $display("FAIL maxlen_early beat=%0d got valid=%b required 0", i, rv[2]);
            end
            beat(2, 16'h0001, 1'b0);
        end
        checks++;
        if (rv[2] !== 1'b1 || rd[2] !== 24'sd4 || rc[2] !== 9'd4 || el[2] !== 1'b1 || rs[2] !== 1'b0) begin
            failures++;
            $display("FAIL maxlen_close got valid=%b data=%0d count=%0d err=%b sat=%b required 1 4 4 1 0",
                     rv[2], rd[2], rc[2], el[2], rs[2]);
        end
        take_result(2);
        beat(2, 16'h0001, 1'b1);
        checks++;
        if (rv[2] !== 1'b1 || rd[2] !== 24'sd1 || rc[2] !== 9'd1 || el[2] !== 1'b0) begin
            failures++;
            $display("FAIL maxlen_next got valid=%b data=%0d count=%0d err=%b required 1 1 1 0",
                     rv[2], rd[2], rc[2], el[2]);
        end
        take_result(2);
    endtask

    task automatic test_reset_mid();
        beat(0, 16'd100, 1'b0);
        beat(0, 16'd100, 1'b0);
        checks++;
        if (rv[0] !== 1'b0) begin
            failures++;
            $display("FAIL mid_no_result got valid=%b required 0", rv[0]);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (rv[0] !== 1'b0 || pr[0] !== 1'b0 || rd[0] !== 24'sd0 || rc[0] !== 9'd0) begin
            failures++;
            $display("FAIL mid_reset got valid=%b ready=%b data=%0d count=%0d required 0 0 0 0",
                     rv[0], pr[0], rd[0], rc[0]);
        end
        beat(0, 16'd7, 1'b1);
        checks++;
        if (rv[0] !== 1'b1 || rd[0] !== 24'sd7 || rc[0] !== 9'd1 || el[0] !== 1'b0) begin
            failures++;
            $display("FAIL mid_after got valid=%b data=%0d count=%0d err=%b required 1 7 1 0",
                     rv[0], rd[0], rc[0], el[0]);
        end
        take_result(0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_saturation();
        test_backpressure();
        test_max_len();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
